// File: rtl/fp_normalize_iter.sv
// Iterative FP normaliser: left shift up to STEP/clk or right by one on carry; 1 to ceil(L/STEP)+2 edges per result.
// Backpressure: one operand in flight, in_ready only in IDLE; result and flags hold in DONE until out_ready.
module fp_normalize_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+1:0]       in_sig,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_word,
    output logic                   out_zero,
    output logic                   out_ovf,
    output logic                   out_denorm,
    output logic                   out_inexact
);
    localparam int LZ_W = $clog2(MAN_W + 2);
    localparam int SW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_sign;
    logic [EXP_W-1:0]   r_exp;
    logic [MAN_W+1:0]   r_sig;
    logic               r_zero, r_ovf, r_denorm, r_inexact;

    logic [SW-1:0]      w_lz, w_expm1, w_lim, w_shamt;
    logic [EXP_W-1:0]   w_exp_inc;

    // Leading zeros of {hidden, fraction}; highest set bit wins as the loop climbs.
    always_comb begin
        w_lz = SW'(MAN_W + 1);
        for (int i = 0; i <= MAN_W; i++) begin
            if (r_sig[i]) w_lz = SW'(MAN_W - i);
        end
        w_expm1   = SW'(r_exp) - SW'(1);
        w_lim     = (SW'(STEP) < w_expm1) ? SW'(STEP) : w_expm1;
        w_shamt   = (w_lz < w_lim) ? w_lz : w_lim;
        w_exp_inc = r_exp + EXP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_sig       <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_denorm    <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= in_sign;
                        r_sig      <= in_sig;
                        r_zero     <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_denorm   <= 1'b0;
                        r_inexact  <= 1'b0;
                        if (in_exp == '1) begin
                            r_exp       <= in_exp;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_exp   <= (in_exp == '0) ? EXP_W'(1) : in_exp;
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (r_sig == '0) begin
                        r_exp       <= '0;
                        r_zero      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_sig[MAN_W+1]) begin
                        r_exp <= w_exp_inc;
                        if (r_sig[0]) r_inexact <= 1'b1;
                        if (w_exp_inc == '1) begin
                            r_sig       <= '0;
                            r_ovf       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_sig <= r_sig >> 1;
                        end
                    end else if (r_sig[MAN_W]) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_exp == EXP_W'(1)) begin
                        r_exp       <= '0;
                        r_denorm    <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        // Shift is capped at exp-1 so the exponent bottoms out at 1.
                        r_sig <= r_sig << w_shamt;
                        r_exp <= r_exp - w_shamt[EXP_W-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_word    = {r_sign, r_exp, r_sig[MAN_W-1:0]};
    assign out_zero    = r_zero;
    assign out_ovf     = r_ovf;
    assign out_denorm  = r_denorm;
    assign out_inexact = r_inexact;
endmodule
